// File: rtl/xocc_dsa_alu_endpoint.sv
// DSA-side endpoint of one XOCC queue pair: pops a command from the FWFT command FIFO,
// executes an ALU or iterative-multiply operation and pushes one response word.
module xocc_dsa_alu_endpoint #(
  parameter int unsigned CMD_WIDTH = 96,
  parameter int unsigned RSP_WIDTH = 32,
  parameter int unsigned CNT_WIDTH = 16
) (
  input  logic                 xocc_clk,
  input  logic                 cpurst_b,
  input  logic                 empty_cmd,
  input  logic [CMD_WIDTH-1:0] dsa_cmd_buffer,
  output logic                 rd_en_cmd,
  input  logic                 full_rsp,
  output logic                 wr_en_rsp,
  output logic [RSP_WIDTH-1:0] dsa_rsp_buffer,
  output logic                 dsa_busy,
  output logic [CNT_WIDTH-1:0] dsa_done_cnt
);

  localparam int unsigned FIELD_W  = 32;
  localparam int unsigned F0_LSB   = 0;
  localparam int unsigned F1_LSB   = 32;
  localparam int unsigned F2_LSB   = 64;
  localparam int unsigned OP_W     = 4;
  localparam int unsigned STEP_W   = 5;

  localparam logic [OP_W-1:0] OP_ADD = 4'd0;
  localparam logic [OP_W-1:0] OP_SUB = 4'd1;
  localparam logic [OP_W-1:0] OP_AND = 4'd2;
  localparam logic [OP_W-1:0] OP_OR  = 4'd3;
  localparam logic [OP_W-1:0] OP_XOR = 4'd4;
  localparam logic [OP_W-1:0] OP_MUL = 4'd5;

  localparam logic [RSP_WIDTH-1:0] BAD_OP = 32'hBAD0_0000;
  localparam logic [STEP_W-1:0]    LAST_STEP = 5'd31;

  typedef enum logic [1:0] {IDLE, EXEC, RSP} state_t;

  state_t                state;
  logic                  armed;
  logic [OP_W-1:0]       opcode;
  logic [RSP_WIDTH-1:0]  op_a;
  logic [RSP_WIDTH-1:0]  op_b;
  logic [RSP_WIDTH-1:0]  acc;
  logic [RSP_WIDTH-1:0]  result;
  logic [STEP_W-1:0]     step;
  logic [RSP_WIDTH-1:0]  alu_result;
  logic [RSP_WIDTH-1:0]  mul_addend;
  logic [RSP_WIDTH-1:0]  acc_next;
  logic                  unused_cmd_bits;

  // Opcode field upper bits carry no meaning.
  assign unused_cmd_bits = ^dsa_cmd_buffer[F0_LSB+FIELD_W-1:F0_LSB+OP_W];

  // armed keeps the pop strobe low while reset is held, even with a command waiting.
  assign rd_en_cmd      = armed && (state == IDLE) && !empty_cmd;
  assign wr_en_rsp      = (state == RSP) && !full_rsp;
  assign dsa_rsp_buffer = result;

  always_comb begin
    alu_result = '0;
    case (opcode)
      OP_ADD:  alu_result = op_a + op_b;
      OP_SUB:  alu_result = op_a - op_b;
      OP_AND:  alu_result = op_a & op_b;
      OP_OR:   alu_result = op_a | op_b;
      OP_XOR:  alu_result = op_a ^ op_b;
      OP_MUL:  alu_result = '0;
      default: alu_result = BAD_OP | RSP_WIDTH'(opcode);
    endcase
  end

  // One shift-add step of the multiplier per EXEC cycle.
  always_comb begin
    mul_addend = '0;
    if (op_b[step]) mul_addend = op_a << step;
    acc_next = acc + mul_addend;
  end

  always_ff @(posedge xocc_clk or negedge cpurst_b) begin
    if (!cpurst_b) begin
      state        <= IDLE;
      armed        <= 1'b0;
      opcode       <= '0;
      op_a         <= '0;
      op_b         <= '0;
      acc          <= '0;
      step         <= '0;
      result       <= '0;
      dsa_busy     <= 1'b0;
      dsa_done_cnt <= '0;
    end else begin
      armed <= 1'b1;
      case (state)
        IDLE: begin
          if (rd_en_cmd) begin
            opcode   <= dsa_cmd_buffer[F0_LSB+OP_W-1:F0_LSB];
            op_a     <= dsa_cmd_buffer[F1_LSB+FIELD_W-1:F1_LSB];
            op_b     <= dsa_cmd_buffer[F2_LSB+FIELD_W-1:F2_LSB];
            acc      <= '0;
            step     <= '0;
            dsa_busy <= 1'b1;
            state    <= EXEC;
          end
        end
        EXEC: begin
          if (opcode == OP_MUL) begin
            acc  <= acc_next;
            step <= step + STEP_W'(1);
            if (step == LAST_STEP) begin
              result <= acc_next;
              state  <= RSP;
            end
          end else begin
            result <= alu_result;
            state  <= RSP;
          end
        end
        RSP: begin
          if (wr_en_rsp) begin
            dsa_done_cnt <= dsa_done_cnt + CNT_WIDTH'(1);
            dsa_busy     <= 1'b0;
            state        <= IDLE;
          end
        end
        default: begin
          dsa_busy <= 1'b0;
          state    <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_xocc_dsa_alu_endpoint.sv
// Directed bench for xocc_dsa_alu_endpoint: models the FWFT command FIFO and rsp FIFO
// handshakes; a second narrow-counter instance exercises counter wrap.
module tb_xocc_dsa_alu_endpoint;

  logic        xocc_clk = 1'b0;
  logic        cpurst_b;
  logic        empty_cmd;
  logic [95:0] dsa_cmd_buffer;
  logic        rd_en_cmd;
  logic        full_rsp;
  logic        wr_en_rsp;
  logic [31:0] dsa_rsp_buffer;
  logic        dsa_busy;
  logic [15:0] dsa_done_cnt;

  logic        rst_w_b;
  logic        rd_w;
  logic        wr_w;
  logic [31:0] rsp_w;
  logic        busy_w;
  logic [3:0]  cnt_w;
  logic [95:0] cmd_w;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  logic [95:0] cmdq[$];
  int          pops[$];
  int          pushes[$];
  logic [31:0] rsps[$];
  logic        busy_hist[$];

  always #5 xocc_clk = ~xocc_clk;

  xocc_dsa_alu_endpoint dut (
    .xocc_clk      (xocc_clk),
    .cpurst_b      (cpurst_b),
    .empty_cmd     (empty_cmd),
    .dsa_cmd_buffer(dsa_cmd_buffer),
    .rd_en_cmd     (rd_en_cmd),
    .full_rsp      (full_rsp),
    .wr_en_rsp     (wr_en_rsp),
    .dsa_rsp_buffer(dsa_rsp_buffer),
    .dsa_busy      (dsa_busy),
    .dsa_done_cnt  (dsa_done_cnt)
  );

  xocc_dsa_alu_endpoint #(.CNT_WIDTH(4)) u_wrap (
    .xocc_clk      (xocc_clk),
    .cpurst_b      (rst_w_b),
    .empty_cmd     (1'b0),
    .dsa_cmd_buffer(cmd_w),
    .rd_en_cmd     (rd_w),
    .full_rsp      (1'b0),
    .wr_en_rsp     (wr_w),
    .dsa_rsp_buffer(rsp_w),
    .dsa_busy      (busy_w),
    .dsa_done_cnt  (cnt_w)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive();
    empty_cmd = (cmdq.size() == 0);
    if (cmdq.size() != 0) dsa_cmd_buffer = cmdq[0];
  endtask

  task automatic push_cmd(input logic [31:0] f0, input logic [31:0] a, input logic [31:0] b);
    cmdq.push_back({b, a, f0});
    drive();
    #1;
  endtask

  // One clock cycle: sample strobes before the edge, apply FIFO effects after it.
  task automatic tick();
    logic        p;
    logic        w;
    logic [31:0] d;
    p = rd_en_cmd;
    w = wr_en_rsp;
    d = dsa_rsp_buffer;
    busy_hist.push_back(dsa_busy);
    check("rd_wr_exclusive", {31'b0, p & w}, 32'd0);
    @(posedge xocc_clk);
    #1;
    if (p) begin
      pops.push_back(cyc);
      if (cmdq.size() != 0) void'(cmdq.pop_front());
    end
    if (w) begin
      pushes.push_back(cyc);
      rsps.push_back(d);
    end
    cyc++;
    drive();
    #1;
  endtask

  task automatic wait_pops(input int n);
    for (int i = 0; i < 200 && pops.size() < n; i++) tick();
    check("pop_timeout", pops.size(), n);
  endtask

  task automatic wait_pushes(input int n);
    for (int i = 0; i < 200 && pushes.size() < n; i++) tick();
    check("push_timeout", pushes.size(), n);
  endtask

  initial begin
    int  t;
    int  t_drop;
    int  nw;
    logic all_busy;
    logic ww;

    cpurst_b       = 1'b0;
    rst_w_b        = 1'b0;
    full_rsp       = 1'b0;
    empty_cmd      = 1'b1;
    dsa_cmd_buffer = '0;
    cmd_w          = {32'd1, 32'd1, 32'd0};

    // Reset with a command already waiting: nothing may be popped.
    push_cmd(32'd0, 32'hFFFF_FFFF, 32'd2);
    repeat (2) @(posedge xocc_clk);
    #1;
    check("rst_rd_en", {31'b0, rd_en_cmd}, 32'd0);
    check("rst_wr_en", {31'b0, wr_en_rsp}, 32'd0);
    check("rst_rsp", dsa_rsp_buffer, 32'd0);
    check("rst_busy", {31'b0, dsa_busy}, 32'd0);
    check("rst_cnt", {16'b0, dsa_done_cnt}, 32'd0);
    cpurst_b = 1'b1;

    // ADD wraps mod 2^32
    wait_pops(1);
    t = pops[0];
    wait_pushes(1);
    check("add_latency", pushes[0] - t, 32'd2);
    check("add_rsp", rsps[0], 32'h0000_0001);
    check("add_cnt", {16'b0, dsa_done_cnt}, 32'd1);

    // MUL: 33-cycle latency, busy across EXEC and RSP
    push_cmd(32'd5, 32'h0001_0003, 32'h0000_0100);
    wait_pops(2);
    t = pops[1];
    wait_pushes(2);
    check("mul_latency", pushes[1] - t, 32'd33);
    check("mul_rsp", rsps[1], 32'h0100_0300);
    check("mul_busy_at_pop", {31'b0, busy_hist[t]}, 32'd0);
    all_busy = 1'b1;
    for (int i = t + 1; i <= t + 33; i++) all_busy &= busy_hist[i];
    check("mul_busy_window", {31'b0, all_busy}, 32'd1);
    check("mul_busy_after", {31'b0, dsa_busy}, 32'd0);

    // Back-to-back queue; F0 upper bits must be ignored
    push_cmd(32'd1, 32'd5, 32'd7);
    push_cmd(32'hABCD_EF14, 32'h0000_F0F0, 32'h0000_0FF0);
    push_cmd(32'd9, 32'd0, 32'd0);
    wait_pushes(5);
    check("b2b_sub", rsps[2], 32'hFFFF_FFFE);
    check("b2b_xor", rsps[3], 32'h0000_FF00);
    check("b2b_badop", rsps[4], 32'hBAD0_0009);
    check("b2b_gap0", pops[3] - pops[2], 32'd3);
    check("b2b_gap1", pops[4] - pops[3], 32'd3);
    check("b2b_cnt", {16'b0, dsa_done_cnt}, 32'd5);

    // Response FIFO full for 10 cycles while in RSP
    full_rsp = 1'b1;
    push_cmd(32'd2, 32'hF0F0_F0F0, 32'hFF00_FF00);
    push_cmd(32'd3, 32'hF0F0_F0F0, 32'hFF00_FF00);
    wait_pops(6);
    tick();
    for (int i = 0; i < 10; i++) begin
      check("stall_wr_en", {31'b0, wr_en_rsp}, 32'd0);
      check("stall_rd_en", {31'b0, rd_en_cmd}, 32'd0);
      check("stall_rsp", dsa_rsp_buffer, 32'hF000_F000);
      tick();
    end
    check("stall_no_pop", pops.size(), 32'd6);
    full_rsp = 1'b0;
    #1;
    check("stall_release_wr_en", {31'b0, wr_en_rsp}, 32'd1);
    t_drop = cyc;
    wait_pushes(6);
    check("stall_push_cycle", pushes[5], t_drop);
    check("stall_and_rsp", rsps[5], 32'hF000_F000);
    wait_pushes(7);
    check("stall_or_rsp", rsps[6], 32'hFFF0_FFF0);
    check("stall_cnt", {16'b0, dsa_done_cnt}, 32'd7);

    // Reset at MUL step 10: command discarded, outputs cleared at once
    push_cmd(32'd5, 32'd3, 32'd4);
    wait_pops(8);
    repeat (10) tick();
    cpurst_b = 1'b0;
    #1;
    check("midrst_rsp", dsa_rsp_buffer, 32'd0);
    check("midrst_busy", {31'b0, dsa_busy}, 32'd0);
    check("midrst_cnt", {16'b0, dsa_done_cnt}, 32'd0);
    check("midrst_wr_en", {31'b0, wr_en_rsp}, 32'd0);
    tick();
    tick();
    cpurst_b = 1'b1;
    push_cmd(32'd0, 32'd10, 32'd20);
    wait_pushes(8);
    check("midrst_next_rsp", rsps[7], 32'd30);
    check("midrst_next_cnt", {16'b0, dsa_done_cnt}, 32'd1);
    check("midrst_pops", pops.size(), 32'd9);

    // Done counter wrap on a 4-bit instance
    rst_w_b = 1'b1;
    nw = 0;
    for (int i = 0; i < 300 && nw < 17; i++) begin
      ww = wr_w;
      @(posedge xocc_clk);
      #1;
      if (ww) begin
        nw++;
        if (nw == 15) check("wrap_cnt15", 32'(cnt_w), 32'd15);
        if (nw == 16) check("wrap_cnt16", 32'(cnt_w), 32'd0);
        if (nw == 17) check("wrap_cnt17", 32'(cnt_w), 32'd1);
      end
    end
    check("wrap_push_count", nw, 32'd17);
    check("wrap_rsp", rsp_w, 32'd2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
